score_digit_driver: RTL and testbench
=====================================

# score_digit_driver

Per-pixel driver that sits directly upstream of the transparent digit sprite renderer. Accepts a binary score, converts it to BCD with a sequential double-dabble engine, holds digits in a tear-free display register updated only at frame start, and for every pixel presents the digit value and sprite origin for the slot containing the current beam position. A leading-zero enable is aligned to the renderer's `draw_out` so the consumer can AND the two.

## Interface
- `NUM_DIGITS`, 4: displayed digits (1–4); score range 0..10^NUM_DIGITS−1.
- `WIDTH`, 24: digit glyph width in pixels; must match the renderer.
- `HEIGHT`, 24: digit glyph height; must match the renderer.
- `GAP`, 8: blank pixels between glyphs. Must be ≥ 6 (see Timing).
- `BLANK_LEADING`, 1: 1 = suppress leading zeros; the least-significant digit is never blanked.
- `pixel_clk_in`  in  1  sole clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `score_in`  in  14  binary score, sampled when `score_valid_in`=1.
- `score_valid_in`  in  1  single-cycle load strobe.
- `origin_x_in`  in  11  left edge of the most-significant digit slot.
- `origin_y_in`  in  10  top edge of the digit row.
- `hcount_in`  in  11  beam x.
- `vcount_in`  in  10  beam y.
- `number_out`  out  4  BCD digit for the current slot; drives renderer `number`.
- `x_out`  out  11  slot sprite x; drives renderer `x_in`.
- `y_out`  out  10  equals `origin_y_in`, registered; drives renderer `y_in`.
- `hcount_out`  out  11  `hcount_in` delayed 1 cycle; drives renderer `hcount_in`.
- `vcount_out`  out  10  `vcount_in` delayed 1 cycle; drives renderer `vcount_in`.
- `digit_en_out`  out  1  0 = blanked slot; aligned with renderer `draw_out`.
- `busy_out`  out  1  conversion in progress.
- `overflow_out`  out  1  displayed value was saturated.

## Operation
- Saturation: if `score_in` > 10^NUM_DIGITS−1, convert 10^NUM_DIGITS−1 and tag overflow = 1. Otherwise overflow = 0.
- FSM states:
  - IDLE: on `score_valid_in`, load the shift register and go to SHIFT.
  - SHIFT: runs 14 cycles. Each cycle, add 3 to every BCD nibble ≥ 5, then shift left by 1.
  - DONE: one cycle. Copy the BCD nibbles and the overflow tag into the shadow register, then go to IDLE.
- Request while busy (SHIFT/DONE):
  - Latch into a one-deep pending register; a later request overwrites it.
  - IDLE starts the pending request on the next cycle and clears the pending flag.
  - A strobe arriving in the same cycle the pending request is consumed becomes the new pending value.
- Display register: loaded from the shadow register in the cycle where `hcount_in`==0 and `vcount_in`==0.
  - If DONE writes the shadow in that same cycle, the display takes the new shadow value (write-through).
  - `overflow_out` is taken from the display register.
- Slot selection:
  - PITCH = WIDTH+GAP.
  - Slot k (k=0 is most significant) covers hcount in [origin_x + k·PITCH, origin_x + (k+1)·PITCH).
  - Left of slot 0, select slot 0; right of the last slot, select the last slot.
  - `x_out` = origin_x + k·PITCH.
  - `number_out` = display digit k.
  - No division: compare against NUM_DIGITS precomputed boundaries.
- Blanking:
  - A slot is blank when BLANK_LEADING=1, its digit is 0, and all more-significant digits are 0.
  - Slot NUM_DIGITS−1 is never blank.
- Reset:
  - Returns the FSM to IDLE and clears the pending flag.
  - Clears shadow and display to 0 and overflow to 0.
  - All outputs go to 0.
  - Reset during SHIFT aborts the conversion and leaves no shadow update.

## Timing
- Conversion latency: `score_valid_in` in cycle t.
  - `busy_out`=1 in cycles t+1..t+15.
  - Shadow valid at t+16.
  - Visible from the next frame start.
- Throughput: one conversion per 16 cycles.
- `number_out`, `x_out`, `y_out`, `hcount_out`, `vcount_out` are registered, with 1-cycle latency from `hcount_in`/`vcount_in`.
- `digit_en_out` is delayed 5 cycles from `hcount_in` (1 here + 4 in the renderer).
- GAP ≥ 6 is required because the renderer compares 4-cycle-delayed counts against the current `x_out`. The slot switch must occur while the old glyph's delayed pixels are finished and the new glyph's have not begun.

## Test plan
- Reset, then a frame with no load → all slots show 0. With BLANK_LEADING=1, `digit_en_out` is 1 only for slot 3.
- Load 1234 at t → `busy_out` high for cycles t+1..t+15. After the next frame start, slots output 1,2,3,4 with `x_out` = origin, +32, +64, +96 (defaults).
- Load 12000 → digits 9,9,9,9 and `overflow_out`=1 from the next frame. Then load 5 → digits 0,0,0,5 and `overflow_out`=0; slots 0–2 blanked.
- Load 111, then 222 and 333 during busy → two conversions run (111, then 333); 222 is never displayed.
- Conversion completes mid-frame → display unchanged until `hcount_in`=`vcount_in`=0. DONE coincident with frame start → new value shown that frame.
- Assert `rst_in` at cycle 7 of a SHIFT → `busy_out`=0 next cycle, display/shadow 0, no stale update afterwards.

Source files
------------

// File: rtl/score_digit_driver.sv
// Score-to-sprite driver: binary score -> BCD via serial double-dabble, frame-synchronous
// display latch, per-pixel slot selection and leading-zero enable for the digit renderer.
module score_digit_driver #(
    parameter int NUM_DIGITS    = 4,
    parameter int WIDTH         = 24,
    parameter int HEIGHT        = 24,
    parameter int GAP           = 8,
    parameter int BLANK_LEADING = 1
) (
    input  logic        pixel_clk_in,
    input  logic        rst_in,
    input  logic [13:0] score_in,
    input  logic        score_valid_in,
    input  logic [10:0] origin_x_in,
    input  logic [9:0]  origin_y_in,
    input  logic [10:0] hcount_in,
    input  logic [9:0]  vcount_in,
    output logic [3:0]  number_out,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        digit_en_out,
    output logic        busy_out,
    output logic        overflow_out
);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 4 || GAP < 6 || HEIGHT < 1) begin : g_param_check
        $error("score_digit_driver: unsupported parameter set");
    end

    localparam int PITCH = WIDTH + GAP;
    localparam int MAXV  = (NUM_DIGITS >= 4) ? 9999 :
                           (NUM_DIGITS == 3) ? 999  :
                           (NUM_DIGITS == 2) ? 99   : 9;
    localparam logic [13:0] MAX_SCORE = 14'(MAXV);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t      r_state, w_state_nxt;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_conv_ovf;
    logic        r_pend_vld;
    logic [13:0] r_pend;
    logic [15:0] r_shadow;
    logic        r_shadow_ovf;
    logic [15:0] r_disp;
    logic        r_disp_ovf;

    logic        w_start, w_use_pend, w_done, w_sat, w_frame;
    logic [13:0] w_src;
    logic [15:0] w_adj;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_use_pend  = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend_vld) begin
                    w_start     = 1'b1;
                    w_use_pend  = 1'b1;
                    w_state_nxt = S_SHIFT;
                end else if (score_valid_in) begin
                    w_start     = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: if (r_cnt == 4'd13) w_state_nxt = S_DONE;
            S_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign w_src = w_use_pend ? r_pend : score_in;
    assign w_sat = (w_src > MAX_SCORE);

    // A strobe that cannot start immediately (busy, or pending already queued ahead) is parked.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_pend_vld <= 1'b0;
            r_pend     <= '0;
        end else if (score_valid_in && (r_state != S_IDLE || r_pend_vld)) begin
            r_pend_vld <= 1'b1;
            r_pend     <= score_in;
        end else if (w_use_pend) begin
            r_pend_vld <= 1'b0;
        end
    end

    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_conv_ovf <= 1'b0;
        end else if (w_start) begin
            r_bin      <= w_sat ? MAX_SCORE : w_src;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_conv_ovf <= w_sat;
        end else if (r_state == S_SHIFT) begin
            r_bcd <= (w_adj << 1) | 16'(r_bin[13]);
            r_bin <= r_bin << 1;
            r_cnt <= r_cnt + 4'd1;
        end
    end

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_shadow     <= '0;
            r_shadow_ovf <= 1'b0;
        end else if (w_done) begin
            r_shadow     <= r_bcd;
            r_shadow_ovf <= r_conv_ovf;
        end
    end

    assign w_frame = (hcount_in == '0) && (vcount_in == '0);

    // Write-through: a conversion finishing on the frame-start cycle is shown this frame.
    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_disp     <= '0;
            r_disp_ovf <= 1'b0;
        end else if (w_frame) begin
            r_disp     <= w_done ? r_bcd : r_shadow;
            r_disp_ovf <= w_done ? r_conv_ovf : r_shadow_ovf;
        end
    end

    logic [1:0]  w_slot;
    logic [10:0] w_slot_x;
    logic [11:0] w_bound;
    logic [3:0]  w_digit;
    logic        w_en, w_zero_run;

    always_comb begin
        w_slot   = '0;
        w_slot_x = origin_x_in;
        w_bound  = '0;
        for (int unsigned k = 1; k < NUM_DIGITS; k++) begin
            w_bound = {1'b0, origin_x_in} + 12'(k * PITCH);
            if ({1'b0, hcount_in} >= w_bound) begin
                w_slot   = 2'(k);
                w_slot_x = w_bound[10:0];
            end
        end
    end

    // Slot 0 holds the most-significant nibble of the display register.
    always_comb begin
        w_digit    = '0;
        w_en       = 1'b1;
        w_zero_run = 1'b1;
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            w_zero_run = w_zero_run && (r_disp[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            if (w_slot == 2'(k)) begin
                w_digit = r_disp[4*(NUM_DIGITS-1-k) +: 4];
                w_en    = !((BLANK_LEADING != 0) && w_zero_run && (k != NUM_DIGITS - 1));
            end
        end
    end

    logic [3:0]  r_number;
    logic [10:0] r_x, r_hc;
    logic [9:0]  r_y, r_vc;
    logic [4:0]  r_en_pipe;

    always_ff @(posedge pixel_clk_in) begin
        if (rst_in) begin
            r_number  <= '0;
            r_x       <= '0;
            r_y       <= '0;
            r_hc      <= '0;
            r_vc      <= '0;
            r_en_pipe <= '0;
        end else begin
            r_number  <= w_digit;
            r_x       <= w_slot_x;
            r_y       <= origin_y_in;
            r_hc      <= hcount_in;
            r_vc      <= vcount_in;
            r_en_pipe <= {r_en_pipe[3:0], w_en};
        end
    end

    assign number_out   = r_number;
    assign x_out        = r_x;
    assign y_out        = r_y;
    assign hcount_out   = r_hc;
    assign vcount_out   = r_vc;
    assign digit_en_out = r_en_pipe[4];
    assign busy_out     = (r_state != S_IDLE);
    assign overflow_out = r_disp_ovf;

endmodule

// File: tb/tb_score_digit_driver.sv
// Scoreboard bench for score_digit_driver: pixel expectations are queued with their due cycle
// and compared when the registered outputs appear.
module tb_score_digit_driver;

    localparam int PITCH = 32;
    localparam int OX    = 200;
    localparam int OY    = 150;

    logic        clk = 1'b0;
    logic        rst;
    logic [13:0] score;
    logic        valid;
    logic [10:0] ox, hc;
    logic [9:0]  oy, vc;
    logic [3:0]  number_out;
    logic [10:0] x_out, hcount_out;
    logic [9:0]  y_out, vcount_out;
    logic        digit_en_out, busy_out, overflow_out;

    score_digit_driver #(
        .NUM_DIGITS(4), .WIDTH(24), .HEIGHT(24), .GAP(8), .BLANK_LEADING(1)
    ) dut (
        .pixel_clk_in(clk), .rst_in(rst), .score_in(score), .score_valid_in(valid),
        .origin_x_in(ox), .origin_y_in(oy), .hcount_in(hc), .vcount_in(vc),
        .number_out(number_out), .x_out(x_out), .y_out(y_out),
        .hcount_out(hcount_out), .vcount_out(vcount_out),
        .digit_en_out(digit_en_out), .busy_out(busy_out), .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [3:0]  num;
        logic [10:0] x;
        logic [9:0]  y;
        logic [10:0] h;
        logic [9:0]  v;
    } pix_t;
    typedef struct {
        int          due;
        logic [10:0] h;
        logic        en;
    } en_t;

    pix_t q_pix[$];
    en_t  q_en[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    int   m_shadow[4];
    int   m_disp[4];
    bit   m_sh_ovf, m_disp_ovf;

    // Advance one cycle; outputs are examined on the falling edge.
    task automatic tick();
        pix_t p;
        en_t  e;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        while (q_pix.size() > 0 && q_pix[0].due <= cyc) begin
            p = q_pix.pop_front();
            checks++;
            if (number_out !== p.num) begin
                errors++;
                $display("FAIL number h=%0d: got %0d expected %0d", p.h, number_out, p.num);
            end
            checks++;
            if (x_out !== p.x) begin
                errors++;
                $display("FAIL x_out h=%0d: got %0d expected %0d", p.h, x_out, p.x);
            end
            checks++;
            if (y_out !== p.y) begin
                errors++;
                $display("FAIL y_out h=%0d: got %0d expected %0d", p.h, y_out, p.y);
            end
            checks++;
            if (hcount_out !== p.h) begin
                errors++;
                $display("FAIL hcount_out: got %0d expected %0d", hcount_out, p.h);
            end
            checks++;
            if (vcount_out !== p.v) begin
                errors++;
                $display("FAIL vcount_out h=%0d: got %0d expected %0d", p.h, vcount_out, p.v);
            end
        end
        while (q_en.size() > 0 && q_en[0].due <= cyc) begin
            e = q_en.pop_front();
            checks++;
            if (digit_en_out !== e.en) begin
                errors++;
                $display("FAIL digit_en h=%0d: got %0b expected %0b", e.h, digit_en_out, e.en);
            end
        end
    endtask

    task automatic drive_pixel(input int h, input int v, input bit chk);
        int   k;
        bit   en;
        pix_t p;
        en_t  e;
        hc = 11'(h);
        vc = 10'(v);
        if (chk) begin
            k = (h < OX) ? 0 : (h - OX) / PITCH;
            if (k > 3) k = 3;
            en = (k == 3);
            for (int j = 0; j <= k; j++) if (m_disp[j] != 0) en = 1'b1;
            p.due = cyc + 1; p.num = 4'(m_disp[k]); p.x = 11'(OX + k * PITCH);
            p.y = 10'(OY); p.h = 11'(h); p.v = 10'(v);
            q_pix.push_back(p);
            e.due = cyc + 5; e.h = 11'(h); e.en = en;
            q_en.push_back(e);
        end
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_pixel(1, 500, 1'b0);
    endtask

    task automatic frame();
        drive_pixel(0, 0, 1'b1);
        m_disp     = m_shadow;
        m_disp_ovf = m_sh_ovf;
        for (int h = OX - 6; h <= OX + 4 * PITCH + 6; h++) drive_pixel(h, OY + 3, 1'b1);
        idle(6);
    endtask

    task automatic set_shadow(input int s);
        int v;
        m_sh_ovf    = (s > 9999);
        v           = m_sh_ovf ? 9999 : s;
        m_shadow[0] = v / 1000;
        m_shadow[1] = (v / 100) % 10;
        m_shadow[2] = (v / 10) % 10;
        m_shadow[3] = v % 10;
    endtask

    task automatic load(input int s);
        score = 14'(s);
        valid = 1'b1;
        tick();
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; score = '0;
        ox = 11'(OX); oy = 10'(OY); hc = 11'd1; vc = 10'd500;
        tick(); tick(); tick();
        checks++;
        if ({number_out, x_out, y_out, hcount_out, vcount_out, digit_en_out, busy_out, overflow_out} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got num=%0d x=%0d y=%0d hc=%0d vc=%0d en=%0b busy=%0b ovf=%0b expected all 0",
                     number_out, x_out, y_out, hcount_out, vcount_out, digit_en_out, busy_out, overflow_out);
        end
        rst = 1'b0;
        set_shadow(0);
        frame();
    endtask

    task automatic test_convert();
        load(1234);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL busy_t+1: got %0b expected 1", busy_out); end
        for (int i = 2; i <= 15; i++) begin
            tick();
            checks++;
            if (busy_out !== 1'b1) begin errors++; $display("FAIL busy_t+%0d: got %0b expected 1", i, busy_out); end
        end
        tick();
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL busy_t+16: got %0b expected 0", busy_out); end
        set_shadow(1234);
        frame();
        checks++;
        if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_1234: got %0b expected 0", overflow_out); end
    endtask

    task automatic test_overflow();
        load(12000);
        idle(16);
        set_shadow(12000);
        frame();
        checks++;
        if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_12000: got %0b expected 1", overflow_out); end
        load(5);
        idle(16);
        checks++;
        if (overflow_out !== 1'b1) begin errors++; $display("FAIL ovf_held_until_frame: got %0b expected 1", overflow_out); end
        set_shadow(5);
        frame();
        checks++;
        if (overflow_out !== 1'b0) begin errors++; $display("FAIL ovf_5: got %0b expected 0", overflow_out); end
    endtask

    task automatic test_pending();
        load(111);          // cyc = t+1
        load(222);          // cyc = t+2
        idle(3);
        load(333);          // cyc = t+6, overwrites 222
        idle(10);           // cyc = t+16
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL pend_idle_gap: got %0b expected 0", busy_out); end
        idle(1);
        checks++;
        if (busy_out !== 1'b1) begin errors++; $display("FAIL pend_restart: got %0b expected 1", busy_out); end
        set_shadow(111);
        frame();
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL pend_no_third: got %0b expected 0", busy_out); end
        set_shadow(333);
        frame();
    endtask

    task automatic test_midframe();
        load(4321);
        frame();            // frame starts before conversion completes
        set_shadow(4321);
        frame();
    endtask

    task automatic test_coincident();
        load(77);           // cyc = t+1
        idle(14);           // cyc = t+15, the DONE cycle
        set_shadow(77);
        frame();
    endtask

    task automatic test_reset_midshift();
        load(5555);         // cyc = t+1
        idle(6);            // cyc = t+7
        rst = 1'b1;
        tick();
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b expected 0", busy_out); end
        checks++;
        if (overflow_out !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b expected 0", overflow_out); end
        rst = 1'b0;
        set_shadow(0);
        m_disp = m_shadow;
        idle(20);
        checks++;
        if (busy_out !== 1'b0) begin errors++; $display("FAIL rst_no_resume: got %0b expected 0", busy_out); end
        frame();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_convert();
        test_overflow();
        test_pending();
        test_midframe();
        test_coincident();
        test_reset_midshift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
